// File: rtl/sample_sender.sv
// sample_sender: fetches count samples from the buffer (rd_req/rd_data/rd_valid) and hands each to the SPI transmitter (send/send_data/send_valid, gated by busy) on start/sample_count/group_mask, reporting active/done
module sample_sender #(
  parameter int COUNT_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic               start,
  input  logic [COUNT_W-1:0] sample_count,
  input  logic [3:0]         group_mask,
  output logic               rd_req,
  input  logic [31:0]        rd_data,
  input  logic               rd_valid,
  output logic               send,
  output logic [31:0]        send_data,
  output logic [3:0]         send_valid,
  input  logic               busy,
  output logic               active,
  output logic               done
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, WAIT_IDLE, SEND, GUARD, DRAIN} state_t;
  state_t state, state_n;
  logic [COUNT_W-1:0] remaining;
  logic [3:0] mask;
  logic last, go, empty_go, retire;
  assign last = remaining == COUNT_W'(1);
  assign go = state == IDLE && start && sample_count != '0;
  assign empty_go = state == IDLE && start && sample_count == '0;
  assign retire = state == GUARD || state == DRAIN;
  always_comb begin
    state_n = state;
    send = 1'b0;
    case (state)
      IDLE:            state_n = go ? FETCH : IDLE;
      FETCH:           state_n = WAIT_DATA;
      WAIT_DATA:       state_n = rd_valid ? (mask != 4'h0 ? SEND : DRAIN) : WAIT_DATA;
      SEND, WAIT_IDLE: begin
        send = !busy;
        state_n = busy ? WAIT_IDLE : GUARD;
      end
      GUARD, DRAIN:    state_n = last ? IDLE : FETCH;
      default:         state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state <= IDLE;
      rd_req <= 1'b0;
      done <= 1'b0;
      active <= 1'b0;
      send_data <= '0;
      send_valid <= '0;
      remaining <= '0;
      mask <= '0;
    end else begin
      state <= state_n;
      rd_req <= state == FETCH;
      done <= empty_go || (retire && last);
      active <= go || (active && !done);
      if (state == IDLE && start) begin
        remaining <= sample_count;
        mask <= group_mask;
      end else if (retire && remaining != '0) begin
        remaining <= remaining - 1'b1;
      end
      if (state == WAIT_DATA && rd_valid) begin
        send_data <= rd_data;
        send_valid <= mask;
      end
    end
  end
endmodule

// File: tb/tb_sample_sender.sv
// tb_sample_sender: randomized transfers against buffer/transmitter models, checked with immediate assertions
module tb_sample_sender;
  localparam int COUNT_W = 20;
  logic clk = 1'b0;
  logic rst, abort, start;
  logic [COUNT_W-1:0] sample_count;
  logic [3:0] group_mask;
  logic rd_req, rd_valid = 1'b0, send, busy = 1'b0, active, done;
  logic [31:0] rd_data = '0, send_data;
  logic [3:0] send_valid;
  int n_chk, n_fail, cyc, n_req, n_send, n_done, n_rv, bad, rd_idx, busy_left;
  int start_cyc, first_req_cyc, first_rv_cyc, first_send_cyc, last_send_cyc, done_cyc;
  int lat_cfg = 1, blen_cfg = 1;
  bit start_seen, act_seen, act_at_done, act_after_done, prev_done, hold;
  logic [31:0] dataq[$], sq[$];
  logic [3:0] vq[$];
  int pend[$];

  always #5 clk = ~clk;

  sample_sender #(.COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst), .abort(abort), .start(start), .sample_count(sample_count),
    .group_mask(group_mask), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .send(send), .send_data(send_data), .send_valid(send_valid), .busy(busy),
    .active(active), .done(done)
  );

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (start && !start_seen) begin
        start_seen = 1;
        start_cyc = cyc;
      end
      if (rd_req) begin
        if (n_req == 0) first_req_cyc = cyc;
        n_req++;
        pend.push_back(cyc + lat_cfg);
        if (send) bad++;
      end
      if (rd_valid) begin
        if (n_rv == 0) first_rv_cyc = cyc;
        n_rv++;
      end
      if (send) begin
        if (n_send == 0) first_send_cyc = cyc;
        n_send++;
        last_send_cyc = cyc;
        sq.push_back(send_data);
        vq.push_back(send_valid);
        if (busy) bad++;
        busy_left = blen_cfg;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        act_at_done = active;
      end
      if (prev_done) act_after_done = active;
      prev_done = done;
      if (active) act_seen = 1;
      @(posedge clk);
      #1;
      rd_valid = pend.size() > 0 && pend[0] == cyc + 1;
      if (rd_valid) begin
        void'(pend.pop_front());
        rd_data = rd_idx < dataq.size() ? dataq[rd_idx] : $urandom;
        rd_idx++;
      end
      busy = hold || busy_left > 0;
      if (busy_left > 0) busy_left--;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    n_req = 0; n_send = 0; n_done = 0; n_rv = 0; bad = 0; rd_idx = 0;
    start_seen = 0; act_seen = 0; act_at_done = 0; act_after_done = 0;
    sq.delete(); vq.delete(); pend.delete(); dataq.delete();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
  endtask

  task automatic pulse_start(input int cnt, input logic [3:0] m);
    sample_count = cnt[COUNT_W-1:0];
    group_mask = m;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (n_done == 0 && k < lim) begin
      tick();
      k++;
    end
    check("done_timeout", n_done != 0, 1);
    tick(4);
  endtask

  task automatic run_xfer(input int cnt, input logic [3:0] m, input int lat, input int blen, input bit fixed);
    wait_idle();
    clear_log();
    lat_cfg = lat;
    blen_cfg = blen;
    for (int i = 0; i < cnt; i++) dataq.push_back(fixed ? (i + 1) * 32'h11111111 : $urandom);
    pulse_start(cnt, m);
    wait_done(cnt * (lat + blen + 10) + 20);
    check("n_req", n_req, cnt);
    check("n_send", n_send, m != 0 ? cnt : 0);
    check("n_done", n_done, 1);
    check("cadence", bad, 0);
    for (int i = 0; i < sq.size() && i < cnt; i++) begin
      check($sformatf("send_data[%0d]", i), sq[i], dataq[i]);
      check($sformatf("send_valid[%0d]", i), vq[i], m);
    end
    if (cnt == 0) begin
      check("zero_active", act_seen, 0);
      check("zero_done_lat", done_cyc - start_cyc, 1);
    end else begin
      check("active_at_done", act_at_done, 1);
      check("active_after_done", act_after_done, 0);
      check("start_to_req", first_req_cyc - start_cyc, 2);
    end
    if (cnt > 0 && m != 0) begin
      check("send_to_done", done_cyc - last_send_cyc, 2);
      check("rv_to_send", first_send_cyc - first_rv_cyc, 1);
    end
  endtask

  initial begin
    int k;
    rst = 1; abort = 0; start = 0; sample_count = '0; group_mask = '0; hold = 0;
    tick(3);
    check("rst_rd_req", rd_req, 0);
    check("rst_send", send, 0);
    check("rst_done", done, 0);
    check("rst_active", active, 0);
    check("rst_send_data", send_data, 0);
    check("rst_send_valid", send_valid, 0);
    rst = 0;
    tick(2);
    run_xfer(3, 4'hF, 2, 8, 1);
    run_xfer(0, 4'hF, 2, 8, 0);
    run_xfer(2, 4'h3, $urandom_range(1, 4), $urandom_range(1, 10), 0);
    run_xfer(2, 4'h0, $urandom_range(1, 4), $urandom_range(1, 10), 0);
    repeat (4) run_xfer($urandom_range(1, 6), 4'($urandom_range(0, 15)), $urandom_range(1, 4), $urandom_range(1, 10), 0);
    wait_idle();
    clear_log();
    lat_cfg = 2;
    blen_cfg = 3;
    repeat (5) dataq.push_back($urandom);
    pulse_start(5, 4'hF);
    k = 0;
    while (!(rd_valid && n_send >= 2) && k < 300) begin
      tick();
      k++;
    end
    check("abort_point_sends", n_send, 2);
    check("abort_point_rv", rd_valid, 1);
    abort = 1;
    tick();
    abort = 0;
    check("abort_active", active, 0);
    check("abort_send_data", send_data, 0);
    check("abort_send_valid", send_valid, 0);
    tick(40);
    check("abort_no_send", n_send, 2);
    check("abort_no_done", n_done, 0);
    check("abort_no_req", n_req, 3);
    run_xfer(3, 4'hF, 1, 4, 0);
    wait_idle();
    clear_log();
    lat_cfg = 1;
    blen_cfg = 2;
    repeat (3) dataq.push_back($urandom);
    hold = 1;
    tick(2);
    pulse_start(3, 4'hF);
    tick(50);
    check("bp_hold_data_a", send_data, dataq[0]);
    check("bp_hold_nosend_a", n_send, 0);
    pulse_start(7, 4'hA);
    tick(50);
    check("bp_hold_data_b", send_data, dataq[0]);
    check("bp_hold_nosend_b", n_send, 0);
    check("bp_active", active, 1);
    hold = 0;
    wait_done(300);
    check("bp_n_send", n_send, 3);
    check("bp_n_req", n_req, 3);
    check("bp_n_done", n_done, 1);
    check("bp_cadence", bad, 0);
    for (int i = 0; i < sq.size() && i < 3; i++) begin
      check($sformatf("bp_data[%0d]", i), sq[i], dataq[i]);
      check($sformatf("bp_valid[%0d]", i), vq[i], 4'hF);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
